// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty flags,
// overflow/underflow pulses and an optional first-word-fall-through read port.
module sync_fifo_flagged #(
    parameter int DEPTH         = 32,
    parameter int WIDTH         = 32,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       w_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       r_en,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             wr_acc, rd_acc;

    always_comb begin
        rd_acc   = r_en && !empty_q;
        // a full FIFO still takes a write when the same edge frees a slot
        wr_acc   = w_en && (!full_q || rd_acc);

        wr_ptr_d = wr_ptr_q;
        if (wr_acc)
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        rd_ptr_d = rd_ptr_q;
        if (rd_acc)
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);

        count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= CW'(AFULL_THRESH));
        aempty_d = (count_d <= CW'(AEMPTY_THRESH));
        ovf_d    = w_en && !wr_acc;
        udf_d    = r_en && !rd_acc;

        dout_d   = dout_q;
        if (rd_acc)
            dout_d = mem[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            dout_q   <= dout_d;
        end
    end

    // storage is not reset; stale words are unreachable once the pointers clear
    always_ff @(posedge clk) begin
        if (!rst && wr_acc)
            mem[wr_ptr_q] <= data_in;
    end

    // fall-through reads the head directly from registered state, so no path from r_en/w_en
    assign data_out     = (FWFT != 0) ? mem[rd_ptr_q] : dout_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Directed bench for sync_fifo_flagged: three instances (DEPTH=4 standard, DEPTH=5 standard,
// DEPTH=4 fall-through) checked against a count model and a data scoreboard queue.
module tb_sync_fifo_flagged;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       w_en [3];
    logic       r_en [3];
    logic [7:0] din  [3];
    logic [7:0] dout [3];
    logic       full [3];
    logic       empty [3];
    logic       afull [3];
    logic       aempty [3];
    logic [2:0] cnt  [3];
    logic       ovf  [3];
    logic       udf  [3];

    int         checks = 0;
    int         errors = 0;

    logic [7:0] sb [$];
    int         mcnt;
    int         mdepth;
    int         mafull;
    logic [7:0] last_out;

    always #5 clk = ~clk;

    sync_fifo_flagged #(.DEPTH(4), .WIDTH(8), .AFULL_THRESH(2), .AEMPTY_THRESH(2), .FWFT(0)) u_d4 (
        .clk(clk), .rst(rst), .w_en(w_en[0]), .data_in(din[0]), .r_en(r_en[0]), .data_out(dout[0]),
        .full(full[0]), .empty(empty[0]), .almost_full(afull[0]), .almost_empty(aempty[0]),
        .count(cnt[0]), .overflow(ovf[0]), .underflow(udf[0]));

    sync_fifo_flagged #(.DEPTH(5), .WIDTH(8), .AFULL_THRESH(3), .AEMPTY_THRESH(2), .FWFT(0)) u_d5 (
        .clk(clk), .rst(rst), .w_en(w_en[1]), .data_in(din[1]), .r_en(r_en[1]), .data_out(dout[1]),
        .full(full[1]), .empty(empty[1]), .almost_full(afull[1]), .almost_empty(aempty[1]),
        .count(cnt[1]), .overflow(ovf[1]), .underflow(udf[1]));

    sync_fifo_flagged #(.DEPTH(4), .WIDTH(8), .AFULL_THRESH(2), .AEMPTY_THRESH(2), .FWFT(1)) u_fw (
        .clk(clk), .rst(rst), .w_en(w_en[2]), .data_in(din[2]), .r_en(r_en[2]), .data_out(dout[2]),
        .full(full[2]), .empty(empty[2]), .almost_full(afull[2]), .almost_empty(aempty[2]),
        .count(cnt[2]), .overflow(ovf[2]), .underflow(udf[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus on instance k, then compare every output against the model.
    task automatic step(input int unsigned k, input logic rs, input logic we, input logic re,
                        input logic [7:0] d);
        logic wacc, racc, exp_ovf, exp_udf;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            w_en[i] = 1'b0;
            r_en[i] = 1'b0;
        end
        rst     = rs;
        w_en[k] = we;
        r_en[k] = re;
        din[k]  = d;

        racc = re && (mcnt > 0);
        wacc = we && ((mcnt < mdepth) || racc);
        if (rs) begin
            exp_ovf  = 1'b0;
            exp_udf  = 1'b0;
            mcnt     = 0;
            last_out = 8'h00;
            sb.delete();
        end else begin
            exp_ovf = we && !wacc;
            exp_udf = re && !racc;
            if (racc) last_out = sb.pop_front();
            if (wacc) sb.push_back(d);
            mcnt = mcnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
        end

        @(posedge clk);
        #1;
        chk("count",        32'(cnt[k]),    32'(mcnt));
        chk("full",         32'(full[k]),   32'(mcnt == mdepth));
        chk("empty",        32'(empty[k]),  32'(mcnt == 0));
        chk("almost_full",  32'(afull[k]),  32'(mcnt >= mafull));
        chk("almost_empty", 32'(aempty[k]), 32'(mcnt <= 2));
        chk("overflow",     32'(ovf[k]),    32'(exp_ovf));
        chk("underflow",    32'(udf[k]),    32'(exp_udf));
        if (k != 2)
            chk("data_out", 32'(dout[k]), 32'(last_out));
        else if (mcnt > 0)
            chk("fwft_head", 32'(dout[k]), 32'(sb[0]));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            w_en[i] = 1'b0;
            r_en[i] = 1'b0;
            din[i]  = 8'h00;
        end
        mcnt = 0; mdepth = 4; mafull = 2; last_out = 8'h00;

        // 1: reset, fill, drain on DEPTH=4
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'hA0 + 8'(i));
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8'h00);

        // 2: overflow on full, underflow on empty
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'hB0 + 8'(i));
        step(0, 0, 1, 0, 8'hFF);
        step(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 8'h00);

        // 3: simultaneous access at full and at empty
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'h50 + 8'(i));
        step(0, 0, 1, 1, 8'h55);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8'h00);
        step(0, 0, 1, 1, 8'h66);
        step(0, 0, 0, 1, 8'h00);

        // 4: pointer wrap on DEPTH=5, occupancy held between 1 and 3
        mdepth = 5; mafull = 3;
        step(1, 1, 0, 0, 8'h00);
        step(1, 0, 1, 0, 8'hC0);
        step(1, 0, 1, 0, 8'hC1);
        for (int i = 2; i < 13; i++) step(1, 0, 1, 1, 8'hC0 + 8'(i));
        step(1, 0, 0, 1, 8'h00);
        step(1, 0, 0, 1, 8'h00);

        // 5: first-word-fall-through
        mdepth = 4; mafull = 2;
        step(2, 1, 0, 0, 8'h00);
        step(2, 0, 1, 0, 8'h11);
        step(2, 0, 1, 0, 8'h22);
        step(2, 0, 0, 1, 8'h00);
        step(2, 0, 0, 0, 8'h00);
        step(2, 0, 0, 1, 8'h00);

        // 6: reset mid-operation with a concurrent write
        step(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'h71 + 8'(i));
        step(0, 1, 1, 0, 8'h99);
        step(0, 0, 1, 0, 8'h88);
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 1, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flagged.md
Name: sync_fifo_flagged

Overview:
- Parametrised single-clock FIFO; next generation of the team's synchronous_fifo.
- Adds a fill-level count, programmable almost-full and almost-empty flags, overflow and underflow error pulses, and a first-word-fall-through (FWFT) mode.
- Sits between producer and consumer blocks in the same clock domain; drop-in for fifo_interface-based benches, extended with the new flag signals.

Parameters:
- DEPTH, 32, number of entries; any integer >= 2; pointers wrap at DEPTH-1 (power of two not required).
- WIDTH, 32, data word width in bits.
- AFULL_THRESH, DEPTH-2, almost_full asserts when count >= this value; legal range 1..DEPTH.
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this value; legal range 0..DEPTH-1.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- w_en  in  1  write request.
- data_in  in  WIDTH  write data.
- r_en  in  1  read request (FWFT=1: pop/acknowledge of the head word).
- data_out  out  WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset: rst sampled at a clk edge; overrides w_en and r_en in the same cycle.
  - Pointers = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0, data_out = 0.
  - Reset mid-operation discards all stored content. Memory contents need not be cleared.
- Accept rules, evaluated on registered state at the edge:
  - wr_acc = w_en && (!full || rd_acc)
  - rd_acc = r_en && !empty
- Simultaneous access:
  - Full and w_en && r_en: both accepted; count stays DEPTH; no overflow.
  - Empty and w_en && r_en: write accepted, read rejected; underflow pulses; count becomes 1.
- Rejected accesses:
  - w_en && !wr_acc: data dropped, overflow = 1 for the next cycle only.
  - r_en && !rd_acc: underflow = 1 for the next cycle only, state unchanged.
- Count update: count_next = count + wr_acc - rd_acc. It never exceeds DEPTH and never goes below 0.
- Flags:
  - full, empty, almost_full and almost_empty are registered, computed from count_next.
  - They change in the same cycle as count, i.e. one cycle after the edge that caused the change.
- Pointers: wr_ptr and rd_ptr each increment on accept and wrap from DEPTH-1 to 0.
- FWFT=0 (standard mode):
  - On rd_acc, data_out <= mem[rd_ptr]; valid one cycle after the accepting edge.
  - data_out holds its value otherwise, including on rejected reads.
- FWFT=1 (fall-through mode):
  - data_out presents mem[rd_ptr] whenever empty = 0.
  - A word written into an empty FIFO is visible on data_out in the cycle empty deasserts, one cycle after the write edge.
  - r_en with empty = 0 consumes the head; the next word (if any) appears in the following cycle.
  - data_out is don't-care while empty = 1; the bench must not check it.
- Latency:
  - Write-to-empty-deassert: 1 cycle.
  - Standard read latency: 1 cycle.
  - No combinational path from w_en or r_en to any output.

Test Plan:
1. Reset/fill/drain, DEPTH=4, FWFT=0.
   - Assert rst 2 cycles, then write 0xA0..0xA3 on consecutive cycles.
   - Expect count 1, 2, 3, 4; full = 1 after the 4th write; almost_full = 1 once count >= 2 (AFULL_THRESH=2).
   - Read 4 times: data_out = 0xA0..0xA3, each one cycle after its read; empty = 1 after the last.
2. Overflow and underflow, DEPTH=4.
   - Full FIFO, w_en only with data 0xFF: overflow pulses exactly 1 cycle; count stays 4; 0xFF is never read back.
   - Empty FIFO, r_en only: underflow pulses 1 cycle; data_out unchanged.
3. Simultaneous access.
   - Full FIFO, w_en = r_en = 1 with data 0x55: count stays 4, no overflow; 0x55 is read out last after draining.
   - Empty FIFO, both asserted with 0x66: count becomes 1, underflow pulses; the next read returns 0x66.
4. Wrap-around, DEPTH=5 (non-power-of-two).
   - Stream 13 writes interleaved with reads, count kept between 1 and 3.
   - Output order matches input order exactly across pointer wraps.
5. FWFT=1.
   - Write 0x11 to an empty FIFO: data_out = 0x11 and empty = 0 one cycle later, with no r_en.
   - Write 0x22, pulse r_en once: data_out becomes 0x22 the next cycle.
6. Reset mid-operation.
   - With count = 3, assert rst together with w_en.
   - Next cycle: count = 0, empty = 1, almost_empty = 1, flags cleared.
   - The next write/read pair returns the newly written word only.
